// File: rtl/fft_frame_read_scheduler.sv
// fft_frame_read_scheduler: drains queued FFT ping-pong buffers as paced FRAME_LEN-beat read bursts
// Ports: clk, rst_n (async active-low); enable gates new frames; frame_ready buffer-full pulse;
//   dn_ready downstream accepts a beat; clr_err clears overflow; rd_en/rd_addr registered read beat;
//   frame_start/frame_done frame strobes; busy = not idle; pending_cnt queued frames (0..2);
//   overflow sticky dropped-frame flag; frame_cnt completed frames (wraps).
module fft_frame_read_scheduler #(
    parameter int FRAME_LEN  = 256,
    parameter int ADDR_W     = 8,
    parameter int GAP_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              frame_ready,
    input  logic              dn_ready,
    input  logic              clr_err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              frame_start,
    output logic              frame_done,
    output logic              busy,
    output logic [1:0]        pending_cnt,
    output logic              overflow,
    output logic [CNT_W-1:0]  frame_cnt
);
    localparam int GAP_W = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(FRAME_LEN - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
    typedef enum logic [1:0] {IDLE, READ, GAP} state_t;
    state_t state;
    logic [ADDR_W-1:0] beat;
    logic [GAP_W-1:0] gap;
    logic [2:0] occ;
    logic inc, dec, drop;
    // a frame being read still holds one of the two buffers
    always_comb begin
        occ  = {1'b0, pending_cnt} + {2'b0, state == READ};
        drop = frame_ready && occ >= 3'd2;
        inc  = frame_ready && !drop;
        dec  = state == IDLE && enable && pending_cnt != 2'd0;
    end
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            beat        <= '0;
            gap         <= '0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            pending_cnt <= 2'd0;
            overflow    <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            pending_cnt <= pending_cnt + 2'(inc) - 2'(dec);
            overflow    <= drop || (overflow && !clr_err);
            if (dec) begin
                state       <= READ;
                frame_start <= 1'b1;
                beat        <= '0;
            end else if (state == READ && dn_ready) begin
                rd_en   <= 1'b1;
                rd_addr <= beat;
                beat    <= beat + 1'b1;
                if (beat == LAST_BEAT) begin
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + 1'b1;
                    gap        <= '0;
                    state      <= GAP_CYCLES == 0 ? IDLE : GAP;
                end
            end else if (state == GAP) begin
                gap <= gap + 1'b1;
                if (gap == LAST_GAP) state <= IDLE;
            end
        end
    end
endmodule
